// File: rtl/seg7_scan_driver_if.sv
// Bus bundle between the display data source (master) and seg7_scan_driver (slave).
// Optional dimming build (SEG7_DIMMING_EN) adds the brightness signal.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;
  logic                    hex_mode;
  logic [0:6]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   digit;
  logic                    frame_start;
`ifdef SEG7_DIMMING_EN
  logic [3:0]              brightness;
`endif

  modport master (
    output digits_in, dp_in, blank_lz, hex_mode,
`ifdef SEG7_DIMMING_EN
    output brightness,
`endif
    input  seg, dp, digit, frame_start
  );

  modport slave (
    input  digits_in, dp_in, blank_lz, hex_mode,
`ifdef SEG7_DIMMING_EN
    input  brightness,
`endif
    output seg, dp, digit, frame_start
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed 7-segment scan driver with frame-coherent input snapshot,
// hex/decimal decode, leading-zero blanking, per-digit decimal points and an
// all-anodes-off guard at the start of every digit slot.
// Optional PWM dimming is enabled by defining SEG7_DIMMING_EN.
module seg7_scan_driver #(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 500
) (
  input logic              clk_100MHz,
  input logic              reset,
  seg7_scan_driver_if.slave bus
);
  localparam int TIMER_W = $clog2(TICKS_PER_DIGIT);
  localparam int SEL_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TICKS_PER_DIGIT - 1);
  localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_DIGITS - 1);

  logic [TIMER_W-1:0]      timer;
  logic [SEL_W-1:0]        sel;
  logic                    load_pending;
  logic [4*NUM_DIGITS-1:0] digits_snap;
  logic [NUM_DIGITS-1:0]   dp_snap;
  logic                    blz_snap;
  logic                    hex_snap;

  logic                    timer_tc;
  logic                    load_now;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              cur_nib;
  logic                    in_guard;
  logic                    anode_en;
  logic [0:6]              seg_nxt;
  logic                    dp_nxt;
  logic [NUM_DIGITS-1:0]   digit_nxt;

  function automatic logic [0:6] decode7(input logic [3:0] nib, input logic hex);
    logic [0:6] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    // Letters are only legal in hex mode; decimal mode shows nothing for them.
    if (!hex && nib > 4'h9) s = 7'b1111111;
    return s;
  endfunction

  assign timer_tc = (timer == TIMER_LAST);
  // A new frame begins when the last digit slot ends; the very first frame after reset is forced.
  assign load_now = load_pending || (timer_tc && (sel == SEL_LAST));

  // Slot timer and digit select.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      timer <= '0;
      sel   <= '0;
    end else if (timer_tc) begin
      timer <= '0;
      sel   <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Frame snapshot of all display inputs so a frame never shows mixed data.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      load_pending <= 1'b1;
      digits_snap  <= '0;
      dp_snap      <= '0;
      blz_snap     <= 1'b0;
      hex_snap     <= 1'b0;
    end else if (load_now) begin
      load_pending <= 1'b0;
      digits_snap  <= bus.digits_in;
      dp_snap      <= bus.dp_in;
      blz_snap     <= bus.blank_lz;
      hex_snap     <= bus.hex_mode;
    end
  end

  // Leading-zero mask: digit i blanks when it and every more significant nibble is zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above  = zero_above & (digits_snap[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_above && blz_snap && (i != 0);
    end
  end

`ifdef SEG7_DIMMING_EN
  logic [3:0] pwm_cnt;

  // Free-running PWM phase for brightness control.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign anode_en = !in_guard && ((bus.brightness == 4'hF) || (pwm_cnt < bus.brightness));
`else
  assign anode_en = !in_guard;
`endif

  assign cur_nib  = digits_snap[4*int'(sel) +: 4];
  assign in_guard = (32'(timer) < BLANK_TICKS);

  // Next output values from the current (timer, sel) and snapshot.
  always_comb begin
    seg_nxt   = 7'b1111111;
    dp_nxt    = 1'b1;
    digit_nxt = '1;
    if (!in_guard) begin
      seg_nxt = lz_blank[sel] ? 7'b1111111 : decode7(cur_nib, hex_snap);
      dp_nxt  = ~dp_snap[sel];
    end
    if (anode_en) digit_nxt[sel] = 1'b0;
  end

  // Registered pin drivers; frame_start marks the edge that reloads the snapshot.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      bus.seg         <= 7'b1111111;
      bus.dp          <= 1'b1;
      bus.digit       <= '1;
      bus.frame_start <= 1'b0;
    end else begin
      bus.seg         <= seg_nxt;
      bus.dp          <= dp_nxt;
      bus.digit       <= digit_nxt;
      bus.frame_start <= load_now;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus pushes the expected slot contents
// of each loaded frame, a negedge monitor pops one entry per lit digit slot.
module tb_seg7_scan_driver;
  localparam int N   = 4;
  localparam int T   = 10;
  localparam int B   = 2;
  localparam int LIT = T - B;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus();

  seg7_scan_driver #(
    .NUM_DIGITS(N), .TICKS_PER_DIGIT(T), .BLANK_TICKS(B)
  ) dut (
    .clk_100MHz(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

`ifdef SEG7_DIMMING_EN
  initial bus.brightness = 4'hF;
`endif

  typedef struct {
    int         sel;
    logic [0:6] seg;
    logic       dp;
  } exp_t;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        blz;
    logic        hex;
    logic [0:6]  s0, s1, s2, s3;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic add_vec(input logic [15:0] d, input logic [3:0] p, input logic blz, input logic hex,
                         input logic [0:6] s0, input logic [0:6] s1, input logic [0:6] s2,
                         input logic [0:6] s3);
    vec_t v;
    v.digits = d; v.dp = p; v.blz = blz; v.hex = hex;
    v.s0 = s0; v.s1 = s1; v.s2 = s2; v.s3 = s3;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    bus.digits_in = v.digits;
    bus.dp_in     = v.dp;
    bus.blank_lz  = v.blz;
    bus.hex_mode  = v.hex;
  endtask

  task automatic push_frame(input vec_t v);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.sel = i;
      case (i)
        0: e.seg = v.s0;
        1: e.seg = v.s1;
        2: e.seg = v.s2;
        default: e.seg = v.s3;
      endcase
      e.dp = ~v.dp[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_frame();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL frame_start_timeout: no pulse within 200 cycles");
    end
  endtask

  // Monitor: one scoreboard entry per lit slot, plus the lit length of each slot.
  exp_t       mon_e;
  bit         prev_lit = 1'b0;
  bit         lit;
  int         lit_cnt = 0;
  logic [3:0] d_exp;

  always @(negedge clk) begin
    if (!mon_en || reset) begin
      prev_lit = 1'b0;
      lit_cnt  = 0;
    end else begin
      lit = (bus.digit !== 4'hF);
      if (lit && !prev_lit) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_slot: digit=%b with nothing queued", bus.digit);
        end else begin
          mon_e = exp_q.pop_front();
          d_exp = ~(4'b0001 << mon_e.sel);
          check("digit", 32'(bus.digit), 32'(d_exp));
          check("seg", 32'(bus.seg), 32'(mon_e.seg));
          check("dp", 32'(bus.dp), 32'(mon_e.dp));
        end
        lit_cnt = 1;
      end else if (lit) begin
        lit_cnt++;
      end else if (prev_lit) begin
        check("lit_len", lit_cnt, LIT);
      end
      prev_lit = lit;
    end
  end

  initial begin
    vec_t rv;
    //       digits    dp       blz   hex   ones        tens        hundreds    thousands
    add_vec(16'h1234, 4'b0000, 1'b0, 1'b0, 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111);
    add_vec(16'h5678, 4'b0000, 1'b0, 1'b0, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100);
    add_vec(16'h0050, 4'b0000, 1'b1, 1'b0, 7'b0000001, 7'b0100100, 7'b1111111, 7'b1111111);
    add_vec(16'h0000, 4'b0000, 1'b1, 1'b0, 7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111);
    add_vec(16'h000A, 4'b0000, 1'b0, 1'b0, 7'b1111111, 7'b0000001, 7'b0000001, 7'b0000001);
    add_vec(16'h000A, 4'b0000, 1'b0, 1'b1, 7'b0001000, 7'b0000001, 7'b0000001, 7'b0000001);
    add_vec(16'hEF09, 4'b0100, 1'b0, 1'b0, 7'b0000100, 7'b0000001, 7'b1111111, 7'b1111111);
    add_vec(16'hBCDE, 4'b1010, 1'b0, 1'b1, 7'b0110000, 7'b1000010, 7'b0110001, 7'b1100000);
    add_vec(16'h0102, 4'b0000, 1'b1, 1'b0, 7'b0010010, 7'b0000001, 7'b1001111, 7'b1111111);

    apply(vecs[0]);
    repeat (3) @(negedge clk);
    check("rst_digit", 32'(bus.digit), 32'h0000000F);
    check("rst_seg", 32'(bus.seg), 32'h0000007F);
    check("rst_dp", 32'(bus.dp), 32'h1);
    check("rst_frame_start", 32'(bus.frame_start), 32'h0);
    #2 reset = 1'b0;
    mon_en = 1'b1;

    // Each new vector is applied mid-frame (during sel=1); it must only show from the next frame.
    for (int v = 0; v < vecs.size(); v++) begin
      wait_frame();
      push_frame(vecs[v]);
      repeat (15) @(negedge clk);
      if (v + 1 < vecs.size()) apply(vecs[v + 1]);
    end
    wait_frame();
    repeat (2) @(negedge clk);
    #1 mon_en = 1'b0;
    check("queue_drained", exp_q.size(), 0);

    // Asynchronous reset in the middle of slot 2.
    repeat (23) @(negedge clk);
    check("pre_rst_digit", 32'(bus.digit), 32'h0000000B);
    #2 reset = 1'b1;
    #1;
    check("async_rst_digit", 32'(bus.digit), 32'h0000000F);
    check("async_rst_seg", 32'(bus.seg), 32'h0000007F);
    check("async_rst_dp", 32'(bus.dp), 32'h1);
    check("async_rst_frame_start", 32'(bus.frame_start), 32'h0);
    rv.digits = 16'h9AF0; rv.dp = 4'b0001; rv.blz = 1'b1; rv.hex = 1'b1;
    rv.s0 = 7'b0000001; rv.s1 = 7'b0111000; rv.s2 = 7'b0001000; rv.s3 = 7'b0000100;
    apply(rv);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("post_rst_frame_start", 32'(bus.frame_start), 32'h1);
    check("post_rst_guard_digit", 32'(bus.digit), 32'h0000000F);
    push_frame(rv);
    wait_frame();
    repeat (2) @(negedge clk);
    #1 mon_en = 1'b0;
    check("post_rst_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
